// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings and default size.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package branch_predictor_pkg;

  // Default number of direct-mapped BTB entries (power of two, 4..64).
  localparam int ENTRIES_DEFAULT = 16;

  typedef logic [1:0] cnt_t;

  // Two-bit saturating counter encodings; bit 1 set means "predict taken".
  localparam cnt_t CNT_SNT = 2'b00;
  localparam cnt_t CNT_WNT = 2'b01;
  localparam cnt_t CNT_WT  = 2'b10;
  localparam cnt_t CNT_ST  = 2'b11;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state logic for a 2-bit saturating branch counter.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to commit cnt_next.
// Ports: cnt (current state), taken (resolved outcome), cnt_next (saturated next state).
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != CNT_ST) cnt_next = cnt + 2'd1;
    end else begin
      if (cnt != CNT_SNT) cnt_next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: fetch lookup, decode-stage recovery, statistics.
// Latency: lookup combinational on PCF; HitD registered one cycle; table update on the edge ending a resolving branch.
// Backpressure: StallD holds HitD and defers the update until the branch leaves decode; FlushD clears HitD.
// Ports: clk/rst_n; fetch PCF -> HitF, PredPCF; decode PCD, PCBranchD, BranchD, PCSrcD, StallD, FlushD
//        -> HitD, RecoverD, RecoverPCD; statistics BranchCount, MissCount.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = ENTRIES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCF,
  output logic        HitF,
  output logic [31:0] PredPCF,
  input  logic        StallD,
  input  logic        FlushD,
  output logic        HitD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCBranchD,
  input  logic        BranchD,
  input  logic        PCSrcD,
  output logic        RecoverD,
  output logic [31:0] RecoverPCD,
  output logic [31:0] BranchCount,
  output logic [31:0] MissCount
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  // Valid and counter state are reset; tag/target storage is not (valid=0 masks it).
  logic [ENTRIES-1:0]      valid_q;
  logic [ENTRIES-1:0][1:0] cnt_q;
  logic [TAG_W-1:0]        tag_q    [ENTRIES];
  logic [31:0]             target_q [ENTRIES];

  logic [IDX_W-1:0] idx_f, idx_d;
  logic [TAG_W-1:0] tag_f, tag_d;
  logic             upd;
  logic             hit_d;
  logic [1:0]       cnt_next;

  // Byte-offset bits of the word-aligned PCs carry no information here.
  logic unused_pc;
  assign unused_pc = ^{PCF[1:0], PCD[1:0]};

  assign idx_f = PCF[IDX_W+1:2];
  assign tag_f = PCF[31:IDX_W+2];
  assign idx_d = PCD[IDX_W+1:2];
  assign tag_d = PCD[31:IDX_W+2];

  // Lookup reads the registered table, so a same-cycle update is seen next cycle.
  assign HitF    = valid_q[idx_f] && (tag_q[idx_f] == tag_f) && cnt_q[idx_f][1];
  assign PredPCF = target_q[idx_f];

  assign RecoverD   = BranchD && (HitD ^ PCSrcD);
  assign RecoverPCD = (HitD && !PCSrcD) ? (PCD + 32'd4) : PCBranchD;

  // A stalled branch stays in decode; commit only on the cycle it moves on.
  assign upd   = BranchD && !StallD;
  assign hit_d = valid_q[idx_d] && (tag_q[idx_d] == tag_d);

  sat_counter2 u_sat_counter2 (
    .cnt      (cnt_q[idx_d]),
    .taken    (PCSrcD),
    .cnt_next (cnt_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      cnt_q   <= {ENTRIES{CNT_WNT}};
    end else if (upd) begin
      if (hit_d) begin
        cnt_q[idx_d] <= cnt_next;
      end else if (PCSrcD) begin
        valid_q[idx_d] <= 1'b1;
        cnt_q[idx_d]   <= CNT_WT;
      end
    end
  end

  // Any taken update either refreshes the target of a hit (tag unchanged) or
  // allocates a new entry, so tag and target are written together.
  always_ff @(posedge clk) begin
    if (upd && PCSrcD) begin
      tag_q[idx_d]    <= tag_d;
      target_q[idx_d] <= PCBranchD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      HitD <= 1'b0;
    end else if (FlushD) begin
      HitD <= 1'b0;
    end else if (!StallD) begin
      HitD <= HitF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      BranchCount <= '0;
      MissCount   <= '0;
    end else if (upd) begin
      if (BranchCount != 32'hFFFF_FFFF) BranchCount <= BranchCount + 32'd1;
      if (RecoverD && (MissCount != 32'hFFFF_FFFF)) MissCount <= MissCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic vs a reference model.
// Latency: inputs driven on falling edge, outputs sampled 1ns later, model advanced at each rising edge.
// Backpressure: StallD/FlushD exercised both directed and at random.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PCF, PredPCF, PCD, PCBranchD, RecoverPCD, BranchCount, MissCount;
  logic        HitF, StallD, FlushD, HitD, BranchD, PCSrcD, RecoverD;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(16)) dut (
    .clk(clk), .rst_n(rst_n), .PCF(PCF), .HitF(HitF), .PredPCF(PredPCF),
    .StallD(StallD), .FlushD(FlushD), .HitD(HitD), .PCD(PCD), .PCBranchD(PCBranchD),
    .BranchD(BranchD), .PCSrcD(PCSrcD), .RecoverD(RecoverD), .RecoverPCD(RecoverPCD),
    .BranchCount(BranchCount), .MissCount(MissCount)
  );

  // Reference model: 16 entries, counter held as an integer 0..3.
  bit          m_valid  [16];
  logic [31:0] m_tag    [16];
  logic [31:0] m_target [16];
  int          m_cnt    [16];
  bit          m_hitd;
  logic [31:0] m_bc, m_mc;

  function automatic int idx_of(logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  function automatic logic [31:0] tag_of(logic [31:0] pc);
    return pc / 64;
  endfunction

  function automatic bit m_hitf(logic [31:0] pc);
    int i;
    i = idx_of(pc);
    return m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_cnt[i] >= 2);
  endfunction

  function automatic bit m_recover();
    return BranchD && (m_hitd != PCSrcD);
  endfunction

  function automatic logic [31:0] m_recpc();
    return (m_hitd && !PCSrcD) ? PCD + 32'd4 : PCBranchD;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_cnt[i]   = 1;
    end
    m_hitd = 1'b0;
    m_bc   = 32'd0;
    m_mc   = 32'd0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit hitf_now, rec_now;
    int i;
    if (!rst_n) begin
      m_reset();
      return;
    end
    hitf_now = m_hitf(PCF);
    rec_now  = m_recover();
    if (BranchD && !StallD) begin
      if (m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
      if (rec_now && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
      i = idx_of(PCD);
      if (m_valid[i] && m_tag[i] == tag_of(PCD)) begin
        if (PCSrcD) begin
          m_cnt[i]    = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
          m_target[i] = PCBranchD;
        end else begin
          m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
        end
      end else if (PCSrcD) begin
        m_valid[i]  = 1'b1;
        m_tag[i]    = tag_of(PCD);
        m_target[i] = PCBranchD;
        m_cnt[i]    = 2;
      end
    end
    if (FlushD) m_hitd = 1'b0;
    else if (!StallD) m_hitd = hitf_now;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    BranchD = 0; StallD = 0; FlushD = 0; PCSrcD = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; idle_inputs(); PCF = 32'h0040_0010; PCD = 0; PCBranchD = 0;
    m_reset();
    tick();
    #1;
    vectors++; if (HitF !== 1'b0) begin miscompares++; $display("FAIL reset_hitf got %b want 0", HitF); end
    vectors++; if (HitD !== 1'b0) begin miscompares++; $display("FAIL reset_hitd got %b want 0", HitD); end
    rst_n = 1;
    tick();
    #1;
    vectors++; if (BranchCount !== 32'd0) begin miscompares++; $display("FAIL reset_bc got %h want 0", BranchCount); end
    vectors++; if (MissCount !== 32'd0) begin miscompares++; $display("FAIL reset_mc got %h want 0", MissCount); end
  endtask

  task automatic test_alloc();
    PCD = 32'h0040_0010; PCBranchD = 32'h0040_0100; PCSrcD = 1; BranchD = 1; PCF = 32'h0040_0000;
    #1;
    vectors++; if (RecoverD !== 1'b1) begin miscompares++; $display("FAIL alloc_recover got %b want 1", RecoverD); end
    vectors++; if (RecoverPCD !== 32'h0040_0100) begin miscompares++; $display("FAIL alloc_recpc got %h want 00400100", RecoverPCD); end
    tick();
    idle_inputs(); PCF = 32'h0040_0010;
    #1;
    vectors++; if (HitF !== 1'b1) begin miscompares++; $display("FAIL alloc_hitf got %b want 1", HitF); end
    vectors++; if (PredPCF !== 32'h0040_0100) begin miscompares++; $display("FAIL alloc_pred got %h want 00400100", PredPCF); end
  endtask

  task automatic test_mispredict();
    tick();
    PCD = 32'h0040_0010; PCBranchD = 32'h0040_0100; BranchD = 1; PCSrcD = 0; PCF = 32'h0040_0100;
    #1;
    vectors++; if (HitD !== 1'b1) begin miscompares++; $display("FAIL misp_hitd got %b want 1", HitD); end
    vectors++; if (RecoverD !== 1'b1) begin miscompares++; $display("FAIL misp_recover got %b want 1", RecoverD); end
    vectors++; if (RecoverPCD !== 32'h0040_0014) begin miscompares++; $display("FAIL misp_recpc got %h want 00400014", RecoverPCD); end
    tick();
    idle_inputs(); PCF = 32'h0040_0010;
    #1;
    vectors++; if (HitF !== 1'b0) begin miscompares++; $display("FAIL misp_hitf got %b want 0", HitF); end
    vectors++; if (BranchCount !== 32'd2) begin miscompares++; $display("FAIL misp_bc got %0d want 2", BranchCount); end
    vectors++; if (MissCount !== 32'd2) begin miscompares++; $display("FAIL misp_mc got %0d want 2", MissCount); end
  endtask

  task automatic test_stall_once();
    logic [31:0] bc0;
    bc0 = m_bc;
    PCD = 32'h0040_0020; PCBranchD = 32'h0040_0200; BranchD = 1; PCSrcD = 1; StallD = 1; PCF = 32'h0040_0000;
    tick();
    tick();
    #1;
    vectors++; if (BranchCount !== bc0) begin miscompares++; $display("FAIL stall_bc_held got %0d want %0d", BranchCount, bc0); end
    StallD = 0;
    tick();
    idle_inputs();
    #1;
    vectors++; if (BranchCount !== bc0 + 32'd1) begin miscompares++; $display("FAIL stall_bc_once got %0d want %0d", BranchCount, bc0 + 1); end
  endtask

  task automatic test_flush_stall();
    PCF = 32'h0040_0020;
    #1;
    vectors++; if (HitF !== 1'b1) begin miscompares++; $display("FAIL flush_hitf got %b want 1", HitF); end
    tick();
    #1;
    vectors++; if (HitD !== 1'b1) begin miscompares++; $display("FAIL flush_hitd_pre got %b want 1", HitD); end
    FlushD = 1; StallD = 1;
    tick();
    idle_inputs();
    #1;
    vectors++; if (HitD !== 1'b0) begin miscompares++; $display("FAIL flush_hitd got %b want 0", HitD); end
    vectors++; if (BranchCount !== m_bc) begin miscompares++; $display("FAIL flush_bc got %0d want %0d", BranchCount, m_bc); end
  endtask

  task automatic test_alias();
    PCD = 32'h0040_0050; PCBranchD = 32'h0040_0500; BranchD = 1; PCSrcD = 1; PCF = 32'h0040_0000;
    tick();
    idle_inputs(); PCF = 32'h0040_0050;
    #1;
    vectors++; if (HitF !== 1'b1) begin miscompares++; $display("FAIL alias_new_hitf got %b want 1", HitF); end
    vectors++; if (PredPCF !== 32'h0040_0500) begin miscompares++; $display("FAIL alias_pred got %h want 00400500", PredPCF); end
    PCF = 32'h0040_0010;
    #1;
    vectors++; if (HitF !== 1'b0) begin miscompares++; $display("FAIL alias_old_hitf got %b want 0", HitF); end
  endtask

  task automatic test_same_cycle();
    PCD = 32'h0040_0030; PCF = 32'h0040_0030; PCBranchD = 32'h0040_0300; BranchD = 1; PCSrcD = 1;
    #1;
    vectors++; if (HitF !== 1'b0) begin miscompares++; $display("FAIL same_pre_hitf got %b want 0", HitF); end
    tick();
    idle_inputs();
    #1;
    vectors++; if (HitF !== 1'b1) begin miscompares++; $display("FAIL same_post_hitf got %b want 1", HitF); end
    vectors++; if (HitD !== 1'b0) begin miscompares++; $display("FAIL same_hitd got %b want 0", HitD); end
  endtask

  task automatic test_reset_mid_update();
    PCD = 32'h0040_0040; PCBranchD = 32'h0040_0400; BranchD = 1; PCSrcD = 1; PCF = 32'h0040_0030;
    #2 rst_n = 0;
    m_reset();
    #1;
    vectors++; if (BranchCount !== 32'd0) begin miscompares++; $display("FAIL arst_bc got %0d want 0", BranchCount); end
    vectors++; if (MissCount !== 32'd0) begin miscompares++; $display("FAIL arst_mc got %0d want 0", MissCount); end
    vectors++; if (HitF !== 1'b0) begin miscompares++; $display("FAIL arst_hitf got %b want 0", HitF); end
    tick();
    #1;
    vectors++; if (BranchCount !== 32'd0) begin miscompares++; $display("FAIL arst_edge_bc got %0d want 0", BranchCount); end
    rst_n = 1;
    tick();
    idle_inputs(); PCF = 32'h0040_0040;
    #1;
    vectors++; if (BranchCount !== 32'd1) begin miscompares++; $display("FAIL arst_first_bc got %0d want 1", BranchCount); end
    vectors++; if (HitF !== 1'b1) begin miscompares++; $display("FAIL arst_first_hitf got %b want 1", HitF); end
  endtask

  function automatic logic [31:0] rand_pc();
    return 32'h0040_0000 | ($urandom_range(0, 2) << 6) | ($urandom_range(0, 3) << 2);
  endfunction

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      PCF       = rand_pc();
      PCD       = rand_pc();
      PCBranchD = $urandom & 32'hFFFF_FFFC;
      BranchD   = ($urandom_range(0, 2) != 0);
      PCSrcD    = $urandom_range(0, 1);
      StallD    = ($urandom_range(0, 4) == 0);
      FlushD    = ($urandom_range(0, 5) == 0);
      #1;
      vectors++; if (HitF !== m_hitf(PCF)) begin miscompares++; $display("FAIL rand_hitf cyc %0d got %b want %b", c, HitF, m_hitf(PCF)); end
      if (m_hitf(PCF)) begin
        vectors++; if (PredPCF !== m_target[idx_of(PCF)]) begin miscompares++; $display("FAIL rand_pred cyc %0d got %h want %h", c, PredPCF, m_target[idx_of(PCF)]); end
      end
      vectors++; if (HitD !== m_hitd) begin miscompares++; $display("FAIL rand_hitd cyc %0d got %b want %b", c, HitD, m_hitd); end
      vectors++; if (RecoverD !== m_recover()) begin miscompares++; $display("FAIL rand_recover cyc %0d got %b want %b", c, RecoverD, m_recover()); end
      vectors++; if (RecoverPCD !== m_recpc()) begin miscompares++; $display("FAIL rand_recpc cyc %0d got %h want %h", c, RecoverPCD, m_recpc()); end
      vectors++; if (BranchCount !== m_bc) begin miscompares++; $display("FAIL rand_bc cyc %0d got %0d want %0d", c, BranchCount, m_bc); end
      vectors++; if (MissCount !== m_mc) begin miscompares++; $display("FAIL rand_mc cyc %0d got %0d want %0d", c, MissCount, m_mc); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 0;
    PCF = 0; PCD = 0; PCBranchD = 0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_alloc();
    test_mispredict();
    test_stall_once();
    test_flush_stall();
    test_alias();
    test_same_cycle();
    test_reset_mid_update();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
